// File: rtl/store_to_fetch_if.sv
// store_to_fetch_if: valid/ready redirect channel from store stage to fetch, through the queue
interface store_to_fetch_if #(
    parameter int MASK_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  send_valid;
    logic                  send_ready;
    logic [MASK_WIDTH-1:0] send_mask;
    logic [ADDR_WIDTH-1:0] send_pc;
    logic                  recv_valid;
    logic                  recv_ready;
    logic [MASK_WIDTH-1:0] recv_mask;
    logic [ADDR_WIDTH-1:0] recv_pc;

    modport master (
        output send_valid, send_mask, send_pc, recv_ready,
        input  send_ready, recv_valid, recv_mask, recv_pc
    );

    modport slave (
        input  send_valid, send_mask, send_pc, recv_ready,
        output send_ready, recv_valid, recv_mask, recv_pc
    );
endinterface

// File: rtl/store_to_fetch_queue.sv
// store_to_fetch_queue: DEPTH-entry show-ahead redirect FIFO with same-PC tail merging,
// synchronous flush, occupancy count and a sticky send-while-full error flag
module store_to_fetch_queue #(
    parameter int MASK_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int MERGE_EN   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    store_to_fetch_if.slave        q,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_send_full
);
    localparam int PW = $clog2(DEPTH);

    logic [MASK_WIDTH-1:0] mask_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr, tail_ptr;
    logic                  empty, full, pop, push, push_new, merge_hit;

    assign tail_ptr = wr_ptr - PW'(1);
    assign empty    = count == '0;
    assign full     = count == (PW+1)'(DEPTH);

    assign q.recv_valid = !empty && !flush;
    assign q.recv_mask  = empty ? '0 : mask_mem[rd_ptr];
    assign q.recv_pc    = empty ? '0 : pc_mem[rd_ptr];
    assign pop          = q.recv_valid && q.recv_ready;

    // A lone entry being popped this cycle cannot absorb a merge: it is leaving.
    assign merge_hit = (MERGE_EN != 0) && q.send_valid && !empty && !flush &&
                       q.send_pc == pc_mem[tail_ptr] && !(count == (PW+1)'(1) && pop);

    assign q.send_ready = !full || merge_hit;
    assign push         = q.send_valid && q.send_ready;
    assign push_new     = push && !merge_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            err_send_full <= 1'b0;
        end else begin
            rd_ptr        <= flush ? wr_ptr : pop ? rd_ptr + PW'(1) : rd_ptr;
            wr_ptr        <= push_new ? wr_ptr + PW'(1) : wr_ptr;
            count         <= (flush ? '0 : count - (PW+1)'(pop)) + (PW+1)'(push_new);
            err_send_full <= err_send_full || (q.send_valid && !q.send_ready);
        end
    end

    // Storage needs no reset: pointers and count alone define which slots are live.
    always_ff @(posedge clk) begin
        if (push_new) begin
            mask_mem[wr_ptr] <= q.send_mask;
            pc_mem[wr_ptr]   <= q.send_pc;
        end else if (merge_hit) begin
            mask_mem[tail_ptr] <= mask_mem[tail_ptr] | q.send_mask;
        end
    end
endmodule

// File: tb/tb_store_to_fetch_queue.sv
// tb_store_to_fetch_queue: directed plan scenarios plus random traffic, checked every cycle
// against a queue-based model of the redirect FIFO.
module tb_store_to_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] pc;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] count;
    logic       err_send_full;
    int         tests = 0;
    int         fails = 0;

    store_to_fetch_if #(.MASK_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    store_to_fetch_queue #(.MASK_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .MERGE_EN(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .q(bus.slave),
        .count(count), .err_send_full(err_send_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain queue of packets; each negedge checks outputs, then applies the coming edge.
    ent_t mq[$];
    logic m_err = 1'b0;

    always @(negedge clk) begin
        int n;
        logic rv, pop, merge, sr;
        if (reset) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            n     = mq.size();
            rv    = n != 0 && !flush;
            pop   = rv && bus.recv_ready;
            merge = bus.send_valid && n != 0 && !flush && bus.send_pc == mq[n-1].pc && !(n == 1 && pop);
            sr    = n < DEPTH || merge;
            chk("m_count", 64'(count), 64'(n));
            chk("m_recv_valid", 64'(bus.recv_valid), 64'(rv));
            chk("m_recv_pc", 64'(bus.recv_pc), n != 0 ? 64'(mq[0].pc) : 64'd0);
            chk("m_recv_mask", 64'(bus.recv_mask), n != 0 ? 64'(mq[0].mask) : 64'd0);
            chk("m_send_ready", 64'(bus.send_ready), 64'(sr));
            chk("m_err", 64'(err_send_full), 64'(m_err));
            if (merge) mq[n-1].mask = mq[n-1].mask | bus.send_mask;
            if (flush) mq.delete();
            else if (pop) void'(mq.pop_front());
            if (bus.send_valid && sr && !merge) mq.push_back('{bus.send_mask, bus.send_pc});
            if (bus.send_valid && !sr) m_err = 1'b1;
        end
    end

    task automatic drive(input logic sv, input logic [31:0] m, input logic [31:0] pc,
                         input logic rr, input logic fl);
        bus.send_valid = sv;
        bus.send_mask  = m;
        bus.send_pc    = pc;
        bus.recv_ready = rr;
        flush          = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] m, input logic [31:0] pc);
        drive(1'b1, m, pc, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic pops(input int k);
        for (int i = 0; i < k; i++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_recv_valid", 64'(bus.recv_valid), 64'd0);
        chk("rst_recv_pc", 64'(bus.recv_pc), 64'd0);
        chk("rst_err", 64'(err_send_full), 64'd0);
        #2 reset = 1'b0;
        tick();

        // fill and drain with distinct PCs so nothing merges
        for (int i = 0; i < 4; i++) push(32'(1 << i), 32'h100 + 32'(4 * i));
        #2;
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_send_ready", 64'(bus.send_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            #2;
            chk("drain_pc", 64'(bus.recv_pc), 64'h100 + 64'(4 * i));
            chk("drain_mask", 64'(bus.recv_mask), 64'(1 << i));
            tick();
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        #2;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_recv_valid", 64'(bus.recv_valid), 64'd0);
        chk("drain_recv_pc", 64'(bus.recv_pc), 64'd0);
        tick();

        // merge of same-target redirects
        push(32'h1, 32'h200);
        push(32'h6, 32'h200);
        #2;
        chk("merge_count", 64'(count), 64'd1);
        chk("merge_mask", 64'(bus.recv_mask), 64'h7);
        chk("merge_pc", 64'(bus.recv_pc), 64'h200);
        tick();
        push(32'h8, 32'h300);
        #2;
        chk("merge_count2", 64'(count), 64'd2);
        tick();
        pops(2);

        // merge into the tail of a full queue
        for (int i = 0; i < 4; i++) push(32'h1, 32'h400 + 32'(4 * i));
        drive(1'b1, 32'h10, 32'h40C, 1'b0, 1'b0);
        #2;
        chk("full_merge_ready", 64'(bus.send_ready), 64'd1);
        tick();
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        #2;
        chk("full_merge_count", 64'(count), 64'd4);
        chk("full_merge_err", 64'(err_send_full), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            #2;
            if (i == 3) chk("full_merge_tail", 64'(bus.recv_mask), 64'h11);
            tick();
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0);

        // streaming push+pop at count 2 wraps both pointers
        push(32'h1, 32'h700);
        push(32'h2, 32'h704);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h3, 32'h708 + 32'(4 * i), 1'b1, 1'b0);
            #2;
            chk("stream_pc", 64'(bus.recv_pc), 64'h700 + 64'(4 * i));
            chk("stream_count", 64'(count), 64'd2);
            tick();
        end
        pops(2);

        // flush with a concurrent push
        for (int i = 0; i < 3; i++) push(32'h1, 32'h800 + 32'(4 * i));
        drive(1'b1, 32'hF, 32'h500, 1'b1, 1'b1);
        #2;
        chk("flush_recv_valid", 64'(bus.recv_valid), 64'd0);
        tick();
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        #2;
        chk("flush_count", 64'(count), 64'd1);
        chk("flush_pc", 64'(bus.recv_pc), 64'h500);
        chk("flush_mask", 64'(bus.recv_mask), 64'hF);
        tick();
        pops(1);

        // send into a full queue, then asynchronous reset mid-cycle
        for (int i = 0; i < 4; i++) push(32'h1, 32'h900 + 32'(4 * i));
        drive(1'b1, 32'h1, 32'h600, 1'b0, 1'b0);
        #2;
        chk("err_send_ready", 64'(bus.send_ready), 64'd0);
        tick();
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        #2;
        chk("err_set", 64'(err_send_full), 64'd1);
        tick();
        chk("err_sticky", 64'(err_send_full), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_err", 64'(err_send_full), 64'd0);
        chk("async_recv_valid", 64'(bus.recv_valid), 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        tick();

        // random traffic over a small PC set so merges and full sends happen
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 2) != 0), $urandom, 32'hA00 + 32'(4 * $urandom_range(0, 2)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
            tick();
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
